// File: rtl/ask_fsk_modulator_if.sv
// Bit-stream in / modulated-sample out bundle between the serializer and the modulator.
// Latency: none (wires only).
// Backpressure: none; samples are pushed at the fixed sample rate and must be taken.
//
// Signals:
//   SerIn     serial data bit, valid in the bit_stb cycle
//   bit_stb   one-cycle strobe marking the start of a bit period
//   mode      0 = ASK, 1 = FSK, sampled on bit_stb
//   mod_out   8-bit unsigned sample, midscale 128
//   mod_valid one-cycle pulse when mod_out updates
//   active    modulator is in its ACTIVE state
interface ask_fsk_modulator_if;
    logic       SerIn;
    logic       bit_stb;
    logic       mode;
    logic [7:0] mod_out;
    logic       mod_valid;
    logic       active;

    // master: bit source (drives the bit stream, observes the samples)
    modport master (
        output SerIn,
        output bit_stb,
        output mode,
        input  mod_out,
        input  mod_valid,
        input  active
    );

    // slave: the modulator itself
    modport slave (
        input  SerIn,
        input  bit_stb,
        input  mode,
        output mod_out,
        output mod_valid,
        output active
    );
endinterface

// File: rtl/ask_fsk_modulator.sv
// ASK/FSK modulator: phase-continuous 16-bit accumulator with triangle shaping, 8-bit samples.
// Latency: first sample SAMPLE_DIV clocks after the starting strobe, then one every SAMPLE_DIV clocks.
// Backpressure: none; samples are emitted unconditionally at the sample tick rate.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   mif  slave side of ask_fsk_modulator_if (SerIn/bit_stb/mode in, mod_out/mod_valid/active out)
//
// Parameters:
//   F0_INC      phase increment per sample for FSK bit 0
//   F1_INC      phase increment per sample for FSK bit 1 and the ASK carrier
//   SAMPLE_DIV  clocks per sample tick (>= 2)
//   TIMEOUT     clocks without bit_stb before falling back to IDLE (>= 2)
module ask_fsk_modulator #(
    parameter logic [15:0] F0_INC     = 16'h0400,
    parameter logic [15:0] F1_INC     = 16'h0800,
    parameter int unsigned SAMPLE_DIV = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    ask_fsk_modulator_if.slave   mif
);

    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MIDSCALE  = 8'd128;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          state_q,     state_d;
    logic            bit_q,       bit_d;
    logic            mode_q,      mode_d;
    logic [15:0]     phase_q,     phase_d;
    logic [SW-1:0]   samp_cnt_q,  samp_cnt_d;
    logic [TW-1:0]   to_cnt_q,    to_cnt_d;
    logic [7:0]      mod_out_q,   mod_out_d;
    logic            mod_valid_q, mod_valid_d;

    logic            tick;
    logic            ask_zero;
    logic [15:0]     inc;
    logic [7:0]      p;
    logic [7:0]      tri_val;

    // Tick and shaping work from the registered bit/mode, so a strobe landing
    // on a tick cycle only affects the following tick.
    assign tick     = (samp_cnt_q == SAMP_LAST);
    assign ask_zero = (mode_q == 1'b0) && (bit_q == 1'b0);
    assign inc      = ((mode_q == 1'b0) || (bit_q == 1'b1)) ? F1_INC : F0_INC;

    // Triangle: rising half maps p[6:0] to 0..254, falling half is its complement.
    assign p       = phase_q[15:8];
    assign tri_val = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        mode_d      = mode_q;
        phase_d     = phase_q;
        samp_cnt_d  = samp_cnt_q;
        to_cnt_d    = to_cnt_q;
        mod_out_d   = mod_out_q;
        mod_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                mod_out_d  = MIDSCALE;
                phase_d    = '0;
                samp_cnt_d = '0;
                to_cnt_d   = '0;
                if (mif.bit_stb) begin
                    bit_d   = mif.SerIn;
                    mode_d  = mif.mode;
                    state_d = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                // Sample generation. The carrier keeps advancing during ASK
                // zeros so it is coherent when the next one bit arrives.
                if (tick) begin
                    samp_cnt_d  = '0;
                    phase_d     = phase_q + inc;
                    mod_out_d   = ask_zero ? MIDSCALE : tri_val;
                    mod_valid_d = 1'b1;
                end else begin
                    samp_cnt_d  = samp_cnt_q + 1'b1;
                end

                // Bit bookkeeping. A strobe in the expiry cycle keeps us
                // active; otherwise expiry overrides any tick on the same edge.
                if (mif.bit_stb) begin
                    bit_d    = mif.SerIn;
                    mode_d   = mif.mode;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    mod_out_d   = MIDSCALE;
                    mod_valid_d = 1'b0;
                    phase_d     = '0;
                    samp_cnt_d  = '0;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_q       <= 1'b0;
            mode_q      <= 1'b0;
            phase_q     <= '0;
            samp_cnt_q  <= '0;
            to_cnt_q    <= '0;
            mod_out_q   <= MIDSCALE;
            mod_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            samp_cnt_q  <= samp_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mod_out_q   <= mod_out_d;
            mod_valid_q <= mod_valid_d;
        end
    end

    assign mif.mod_out   = mod_out_q;
    assign mif.mod_valid = mod_valid_q;
    assign mif.active    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_ask_fsk_modulator.sv
// Testbench for ask_fsk_modulator: two instances (long and short timeout) share one
// stimulus stream; each run is checked cycle by cycle against a timeline model
// built from the strobe schedule, plus directed spot values.
module tb_ask_fsk_modulator;

    localparam int MAXC  = 512;
    localparam int DIV   = 4;
    localparam int TMO_A = 1024;
    localparam int TMO_B = 16;
    localparam int F0    = 'h0400;
    localparam int F1    = 'h0800;

    logic clk = 1'b0;
    logic rst;
    logic drv_stb, drv_ser, drv_mode;

    ask_fsk_modulator_if if_a();
    ask_fsk_modulator_if if_b();

    assign if_a.bit_stb = drv_stb;
    assign if_a.SerIn   = drv_ser;
    assign if_a.mode    = drv_mode;
    assign if_b.bit_stb = drv_stb;
    assign if_b.SerIn   = drv_ser;
    assign if_b.mode    = drv_mode;

    ask_fsk_modulator #(
        .F0_INC(16'h0400), .F1_INC(16'h0800), .SAMPLE_DIV(DIV), .TIMEOUT(TMO_A)
    ) dut_a (
        .clk(clk), .rst(rst), .mif(if_a)
    );

    ask_fsk_modulator #(
        .F0_INC(16'h0400), .F1_INC(16'h0800), .SAMPLE_DIV(DIV), .TIMEOUT(TMO_B)
    ) dut_b (
        .clk(clk), .rst(rst), .mif(if_b)
    );

    always #5 clk = ~clk;

    // Stimulus schedule: entry c is presented in cycle c and sampled by edge c.
    bit         stim_stb [MAXC];
    bit         stim_ser [MAXC];
    bit         stim_mode[MAXC];

    // Observations taken after edge c (index 0 = dut_a, 1 = dut_b).
    logic       obs_v[2][MAXC];
    logic       obs_a[2][MAXC];
    logic [7:0] obs_o[2][MAXC];

    // Model expectations after edge c.
    logic       exp_v[MAXC];
    logic       exp_a[MAXC];
    logic [7:0] exp_o[MAXC];

    int samp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic int tri_of(int ph);
        int pp;
        pp = ph / 256;
        return (pp < 128) ? 2 * pp : 255 - 2 * (pp - 128);
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            stim_stb[i]  = 1'b0;
            stim_ser[i]  = 1'b0;
            stim_mode[i] = 1'b0;
        end
    endtask

    task automatic strobe(int c, bit b, bit m);
        stim_stb[c]  = 1'b1;
        stim_ser[c]  = b;
        stim_mode[c] = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv_stb = 1'b0; drv_ser = 1'b0; drv_mode = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_stim(int n);
        for (int c = 0; c < n; c++) begin
            drv_stb  = stim_stb[c];
            drv_ser  = stim_ser[c];
            drv_mode = stim_mode[c];
            @(posedge clk);
            @(negedge clk);
            obs_v[0][c] = if_a.mod_valid; obs_a[0][c] = if_a.active; obs_o[0][c] = if_a.mod_out;
            obs_v[1][c] = if_b.mod_valid; obs_a[1][c] = if_b.active; obs_o[1][c] = if_b.mod_out;
        end
        drv_stb = 1'b0;
    endtask

    // Timeline model: a session opens at a strobe from idle and closes tmo edges
    // after its last strobe; samples fall every DIV edges from the opening strobe,
    // each using the latest strobe strictly before it and the running phase sum.
    task automatic build_model(int n, int tmo);
        int c, s0, last, e, fin, g, ph, cur;
        bit b, m;
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = 1'b0; exp_a[i] = 1'b0; exp_o[i] = 8'd128;
        end
        c = 0;
        while (c < n) begin
            if (!stim_stb[c]) begin
                c++;
                continue;
            end
            s0 = c; last = c; e = c + 1;
            while (e < n && e <= last + tmo) begin
                if (stim_stb[e]) last = e;
                e++;
            end
            fin = last + tmo;
            ph  = 0;
            cur = 128;
            for (int k = s0; k < fin && k < n; k++) begin
                exp_a[k] = 1'b1;
                if (k > s0 && ((k - s0) % DIV) == 0) begin
                    g = k - 1;
                    while (!stim_stb[g]) g--;
                    b = stim_ser[g];
                    m = stim_mode[g];
                    cur = (m == 1'b0 && b == 1'b0) ? 128 : tri_of(ph);
                    ph  = (ph + ((m == 1'b0 || b == 1'b1) ? F1 : F0)) % 65536;
                    exp_v[k] = 1'b1;
                end
                exp_o[k] = 8'(cur);
            end
            c = fin + 1;
        end
    endtask

    task automatic check_run(string name, int n);
        for (int d = 0; d < 2; d++) begin
            build_model(n, (d == 0) ? TMO_A : TMO_B);
            for (int c = 0; c < n; c++) begin
                total++;
                if (obs_a[d][c] !== exp_a[c]) begin
                    bad++;
                    $display("FAIL %s dut%0d edge %0d active got %b want %b", name, d, c, obs_a[d][c], exp_a[c]);
                end
                total++;
                if (obs_v[d][c] !== exp_v[c]) begin
                    bad++;
                    $display("FAIL %s dut%0d edge %0d mod_valid got %b want %b", name, d, c, obs_v[d][c], exp_v[c]);
                end
                total++;
                if (obs_o[d][c] !== exp_o[c]) begin
                    bad++;
                    $display("FAIL %s dut%0d edge %0d mod_out got %0d want %0d", name, d, c, obs_o[d][c], exp_o[c]);
                end
            end
        end
    endtask

    function automatic void collect(int d, int n);
        samp_q.delete();
        for (int c = 0; c < n; c++)
            if (obs_v[d][c] === 1'b1) samp_q.push_back(int'(obs_o[d][c]));
    endfunction

    task automatic test_reset();
        do_reset();
        clear_stim();
        strobe(0, 1'b1, 1'b1);
        run_stim(13);
        check_run("pre_reset", 13);
        // Edge 12 just produced the third sample (32) with mod_valid high.
        rst = 1'b0;
        #1;
        total++;
        if (if_a.mod_out !== 8'd128) begin
            bad++; $display("FAIL reset_async mod_out got %0d want 128", if_a.mod_out);
        end
        total++;
        if (if_a.mod_valid !== 1'b0) begin
            bad++; $display("FAIL reset_async mod_valid got %b want 0", if_a.mod_valid);
        end
        total++;
        if (if_a.active !== 1'b0) begin
            bad++; $display("FAIL reset_async active got %b want 0", if_a.active);
        end
        total++;
        if (if_b.active !== 1'b0) begin
            bad++; $display("FAIL reset_async dut1 active got %b want 0", if_b.active);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_stim();
        run_stim(40);
        check_run("post_reset_idle", 40);
    endtask

    task automatic test_fsk_bit1();
        int first;
        do_reset();
        clear_stim();
        strobe(0, 1'b1, 1'b1);
        run_stim(80);
        check_run("fsk_bit1", 80);
        first = -1;
        for (int c = 79; c >= 0; c--) if (obs_v[0][c] === 1'b1) first = c;
        total++;
        if (first != DIV) begin
            bad++; $display("FAIL fsk_bit1_first_valid edge got %0d want %0d", first, DIV);
        end
        collect(0, 80);
        total++;
        if (samp_q.size() < 18) begin
            bad++; $display("FAIL fsk_bit1_count got %0d want >=18", samp_q.size());
        end else begin
            total++;
            if (samp_q[0] != 0 || samp_q[1] != 16 || samp_q[2] != 32 || samp_q[3] != 48) begin
                bad++;
                $display("FAIL fsk_bit1_ramp got %0d %0d %0d %0d want 0 16 32 48",
                         samp_q[0], samp_q[1], samp_q[2], samp_q[3]);
            end
            total++;
            if (samp_q[16] != 255 || samp_q[17] != 239) begin
                bad++; $display("FAIL fsk_bit1_peak got %0d %0d want 255 239", samp_q[16], samp_q[17]);
            end
        end
    endtask

    task automatic test_fsk_switch();
        do_reset();
        clear_stim();
        strobe(0, 1'b0, 1'b1);
        strobe(32, 1'b1, 1'b1);
        run_stim(80);
        check_run("fsk_switch", 80);
        collect(0, 80);
        total++;
        if (samp_q.size() < 10) begin
            bad++; $display("FAIL fsk_switch_count got %0d want >=10", samp_q.size());
        end else begin
            total++;
            if (samp_q[1] != 8 || samp_q[7] != 56 || samp_q[8] != 64 || samp_q[9] != 80) begin
                bad++;
                $display("FAIL fsk_switch_join got %0d %0d %0d %0d want 8 56 64 80",
                         samp_q[1], samp_q[7], samp_q[8], samp_q[9]);
            end
        end
    endtask

    task automatic test_ask();
        do_reset();
        clear_stim();
        strobe(0,  1'b1, 1'b0);
        strobe(32, 1'b0, 1'b0);
        strobe(64, 1'b1, 1'b0);
        run_stim(110);
        check_run("ask", 110);
        collect(0, 110);
        total++;
        if (samp_q.size() < 18) begin
            bad++; $display("FAIL ask_count got %0d want >=18", samp_q.size());
        end else begin
            total++;
            if (samp_q[7] != 112 || samp_q[8] != 128 || samp_q[15] != 128) begin
                bad++;
                $display("FAIL ask_gap got %0d %0d %0d want 112 128 128", samp_q[7], samp_q[8], samp_q[15]);
            end
            // 16 carrier ticks put the phase at 0x8000 when the one bit resumes.
            total++;
            if (samp_q[16] != 255 || samp_q[17] != 239) begin
                bad++; $display("FAIL ask_resume got %0d %0d want 255 239", samp_q[16], samp_q[17]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        clear_stim();
        strobe(0, 1'b1, 1'b1);
        run_stim(40);
        check_run("timeout", 40);
        total++;
        if (obs_a[1][15] !== 1'b1 || obs_a[1][16] !== 1'b0) begin
            bad++; $display("FAIL timeout_fall active@15=%b @16=%b want 1 0", obs_a[1][15], obs_a[1][16]);
        end
        total++;
        if (obs_o[1][16] !== 8'd128 || obs_v[1][16] !== 1'b0) begin
            bad++; $display("FAIL timeout_idle_wins mod_out=%0d mod_valid=%b want 128 0", obs_o[1][16], obs_v[1][16]);
        end

        do_reset();
        clear_stim();
        strobe(0,  1'b1, 1'b1);
        strobe(16, 1'b0, 1'b1);
        run_stim(50);
        check_run("timeout_rescue", 50);
        total++;
        if (obs_a[1][16] !== 1'b1 || obs_a[1][31] !== 1'b1 || obs_a[1][32] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_rescue active@16=%b @31=%b @32=%b want 1 1 0",
                     obs_a[1][16], obs_a[1][31], obs_a[1][32]);
        end
    endtask

    task automatic test_held_strobe();
        do_reset();
        clear_stim();
        strobe(0, 1'b0, 1'b1);
        strobe(1, 1'b1, 1'b1);
        strobe(2, 1'b0, 1'b1);
        strobe(10, 1'b1, 1'b0);
        strobe(11, 1'b0, 1'b0);
        strobe(12, 1'b1, 1'b1);
        strobe(13, 1'b0, 1'b0);
        run_stim(60);
        check_run("held_strobe", 60);
    endtask

    task automatic test_full_message();
        bit [4:0] msg;
        msg = 5'b10110;
        do_reset();
        clear_stim();
        for (int i = 0; i < 5; i++) strobe(32 * i, msg[4 - i], 1'b1);
        run_stim(180);
        check_run("full_message", 180);
        collect(0, 180);
        total++;
        if (samp_q.size() < 40) begin
            bad++; $display("FAIL full_message_count got %0d want >=40", samp_q.size());
        end else begin
            // Phase at the start of each bit: 0x4000, 0x6000, 0xA000, 0xE000.
            total++;
            if (samp_q[8] != 128 || samp_q[16] != 192 || samp_q[24] != 191 || samp_q[32] != 63) begin
                bad++;
                $display("FAIL full_message_bit_starts got %0d %0d %0d %0d want 128 192 191 63",
                         samp_q[8], samp_q[16], samp_q[24], samp_q[32]);
            end
        end
    endtask

    task automatic test_random();
        int c;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_stim();
            c = $urandom_range(0, 5);
            while (c < 400) begin
                strobe(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                c += (r == 3) ? $urandom_range(1, 3) : $urandom_range(1, 40);
            end
            run_stim(420);
            check_run("random", 420);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        drv_stb  = 1'b0;
        drv_ser  = 1'b0;
        drv_mode = 1'b0;
        test_reset();
        test_fsk_bit1();
        test_fsk_switch();
        test_ask();
        test_timeout();
        test_held_strobe();
        test_full_message();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
